cnu_serial: RTL and testbench

//  Serial min-sum check node unit for the LDPC decoder; counterpart of the VNU on the Q/R message interface.

---
 rtl/cnu_if.sv | 29 ++
 rtl/cnu_serial.sv | 143 ++++++++++++++
 tb/tb_cnu_serial.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cnu_if.sv
// Q/R message interface between a check node unit and its VNU side.
//   in_valid/in_ready/in_q               : variable-to-check message stream (q)
//   out_valid/out_ready/out_r/out_last   : check-to-variable message stream (r)
//   parity_ok                            : check-node parity, meaningful while out_valid
// modport master : the VNU side (drives q, consumes r)
// modport slave  : the check node unit
interface cnu_if #(
  parameter int Q_W = 11,
  parameter int R_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic signed [Q_W-1:0] in_q;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [R_W-1:0] out_r;
  logic                  out_last;
  logic                  parity_ok;

  modport master (
    output in_valid, in_q, out_ready,
    input  in_ready, out_valid, out_r, out_last, parity_ok
  );

  modport slave (
    input  in_valid, in_q, out_ready,
    output in_ready, out_valid, out_r, out_last, parity_ok
  );
endinterface

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit.
// Collects DC q messages (one per accepted cycle), tracks the two smallest
// saturated magnitudes, the index of the first minimum and the sign vector,
// then emits DC r messages in edge order with the extrinsic min and sign.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cnu_if.slave (q input stream, r output stream, parity_ok)
// Optional feature: define OFFSET_MS_EN for offset min-sum (magnitudes
// reduced by OFFSET, floored at 0, at emit time).
module cnu_serial #(
  parameter int DC     = 6,
  parameter int Q_W    = 11,
  parameter int R_W    = 8,
  parameter int OFFSET = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  cnu_if.slave   bus
);
  localparam int MAG_W = R_W - 1;
  localparam int CNT_W = (DC > 1) ? $clog2(DC) : 1;
  localparam logic [MAG_W-1:0] MAX_MAG = '1;
  localparam logic [MAG_W-1:0] OFF_V   = MAG_W'(OFFSET);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DC - 1);
`ifdef OFFSET_MS_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  // |q| saturated to the r magnitude range; -2^(Q_W-1) negates to 2^(Q_W-1)
  // as an unsigned value, so it saturates like any other large magnitude.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [Q_W-1:0] q);
    logic [Q_W-1:0] a;
    a = q[Q_W-1] ? $unsigned(-q) : $unsigned(q);
    if (a > {{(Q_W-MAG_W){1'b0}}, MAX_MAG})
      return MAX_MAG;
    else
      return a[MAG_W-1:0];
  endfunction

  function automatic logic [MAG_W-1:0] offset_mag(input logic [MAG_W-1:0] m);
    return (m > OFF_V) ? (m - OFF_V) : '0;
  endfunction

  function automatic logic signed [R_W-1:0] apply_sign(input logic neg,
                                                      input logic [MAG_W-1:0] m);
    logic signed [R_W-1:0] v;
    v = $signed({1'b0, m});
    return neg ? -v : v;
  endfunction

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt_p0;
  logic [MAG_W-1:0] min1_p0, min2_p0;
  logic [CNT_W-1:0] idx_p0;
  logic [DC-1:0]    sgn_p0;
  logic             sprod_p0;
  logic [CNT_W-1:0] e_p1;

  // Stage 0: collect q, running min1/min2/idx and signs
  logic [MAG_W-1:0] mag_in;
  logic [MAG_W-1:0] min1_cur, min2_cur;
  logic             sprod_cur;
  logic             sgn_in;

  // A new check starts whenever cnt is 0, so the running values restart
  // from max magnitude / even parity without needing a separate clear cycle.
  assign mag_in    = sat_mag(bus.in_q);
  assign sgn_in    = bus.in_q[Q_W-1];
  assign min1_cur  = (cnt_p0 == '0) ? MAX_MAG : min1_p0;
  assign min2_cur  = (cnt_p0 == '0) ? MAX_MAG : min2_p0;
  assign sprod_cur = (cnt_p0 == '0) ? 1'b0    : sprod_p0;

  assign bus.in_ready = (state == COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      cnt_p0   <= '0;
      min1_p0  <= '0;
      min2_p0  <= '0;
      idx_p0   <= '0;
      sgn_p0   <= '0;
      sprod_p0 <= 1'b0;
      e_p1     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            sgn_p0[cnt_p0] <= sgn_in;
            sprod_p0       <= sprod_cur ^ sgn_in;
            // Strict compare: equal magnitudes never displace idx.
            if (mag_in < min1_cur) begin
              min2_p0 <= min1_cur;
              min1_p0 <= mag_in;
              idx_p0  <= cnt_p0;
            end else begin
              min1_p0 <= min1_cur;
              min2_p0 <= (mag_in < min2_cur) ? mag_in : min2_cur;
            end
            if (cnt_p0 == LAST) begin
              cnt_p0 <= '0;
              e_p1   <= '0;
              state  <= EMIT;
            end else begin
              cnt_p0 <= cnt_p0 + 1'b1;
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            if (e_p1 == LAST) begin
              e_p1  <= '0;
              state <= COLLECT;
            end else begin
              e_p1 <= e_p1 + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Stage 1: per-edge extrinsic message from the stored check summary
  logic             vld_p1;
  logic [MAG_W-1:0] m_sel_p1, m_out_p1;
  logic             neg_p1;

  assign vld_p1   = (state == EMIT);
  assign m_sel_p1 = (e_p1 == idx_p0) ? min2_p0 : min1_p0;
  assign m_out_p1 = OFF_EN ? offset_mag(m_sel_p1) : m_sel_p1;
  assign neg_p1   = sprod_p0 ^ sgn_p0[e_p1];

  assign bus.out_valid = vld_p1;
  assign bus.out_r     = vld_p1 ? apply_sign(neg_p1, m_out_p1) : '0;
  assign bus.out_last  = vld_p1 && (e_p1 == LAST);
  assign bus.parity_ok = vld_p1 && !sprod_p0;
endmodule

// File: tb/tb_cnu_serial.sv
// Bench for cnu_serial (DC=6, Q_W=11, R_W=8, OFFSET=1). Expected r values come
// from the min-sum definition: magnitude = min of the other edges' saturated
// magnitudes, sign = parity of the other edges' signs.
module tb_cnu_serial;
  localparam int DC = 6;
  localparam int QW = 11;
  localparam int RW = 8;
  localparam int OFF = 1;
  localparam int MAXM = (1 << (RW - 1)) - 1;

  logic clk;
  logic rst_n;

  cnu_if #(.Q_W(QW), .R_W(RW)) bus ();

  cnu_serial #(.DC(DC), .Q_W(QW), .R_W(RW), .OFFSET(OFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r;
    bit last;
    bit par;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  int s1[6] = '{5, -3, 7, 2, -9, 4};
  int s3[6] = '{-1024, 300, -200, 50, 60, 70};
  int s4[6] = '{4, 4, 4, -8, 9, 10};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_abs(input int q);
    int a;
    a = (q < 0) ? -q : q;
    return (a > MAXM) ? MAXM : a;
  endfunction

  function automatic int model_r(input int q[6], input int e);
    int m;
    int neg;
    m = MAXM;
    neg = 0;
    for (int j = 0; j < DC; j++) begin
      if (j != e) begin
        if (sat_abs(q[j]) < m) m = sat_abs(q[j]);
        if (q[j] < 0) neg++;
      end
    end
`ifdef OFFSET_MS_EN
    m = (m > OFF) ? m - OFF : 0;
`endif
    return (neg % 2 == 1) ? -m : m;
  endfunction

  function automatic bit model_par(input int q[6]);
    int neg;
    neg = 0;
    for (int j = 0; j < DC; j++) if (q[j] < 0) neg++;
    return (neg % 2 == 0);
  endfunction

  // Every cycle r is presented, it must equal the head of the expectation
  // queue; the head is retired only on an accepted transfer, so a stall
  // also proves the outputs hold.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected out_valid", 1, 0);
      end else begin
        cur = expq[0];
        chk("out_r", int'(bus.out_r), cur.r);
        chk("out_last", int'(bus.out_last), int'(cur.last));
        chk("parity_ok", int'(bus.parity_ok), int'(cur.par));
        chk("in_ready during emit", int'(bus.in_ready), 0);
        if (bus.out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic send_q(input int q[6], input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_q     = QW'(q[i]);
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.in_ready) chk("in_ready timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_q     = '0;
  endtask

  task automatic run_check(input int q[6], input int stall_edge,
                           input int stall_n, input int hold_lit);
    int emitted;
    int stalled;
    int t;
    bit hs;
    for (int e = 0; e < DC; e++)
      expq.push_back(exp_t'{model_r(q, e), (e == DC - 1), model_par(q)});
    send_q(q, DC);
    chk("latency out_valid", int'(bus.out_valid), 1);
    emitted = 0;
    stalled = 0;
    t = 0;
    while (emitted < DC && t < 100) begin
      if (emitted == stall_edge && stalled < stall_n) begin
        bus.out_ready = 1'b0;
        stalled++;
        chk("hold out_r", int'(bus.out_r), hold_lit);
        chk("hold in_ready", int'(bus.in_ready), 0);
      end else begin
        bus.out_ready = 1'b1;
      end
      hs = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      if (hs) emitted++;
      t++;
    end
    bus.out_ready = 1'b1;
    chk("emit count", emitted, DC);
    chk("in_ready after emit", int'(bus.in_ready), 1);
    chk("out_valid after emit", int'(bus.out_valid), 0);
    chk("queue drained", expq.size(), 0);
  endtask

  task automatic pin(input string name, input int q[6], input int lit[6],
                     input bit par);
    for (int e = 0; e < DC; e++)
      chk($sformatf("%s r%0d", name, e), model_r(q, e), lit[e]);
    chk($sformatf("%s parity", name), int'(model_par(q)), int'(par));
  endtask

  initial begin
    int l1[6];
    int l3[6];
    int l4[6];
`ifdef OFFSET_MS_EN
    l1 = '{1, -1, 1, 2, -1, 1};
    l3 = '{-49, 49, -49, 59, 49, 49};
    l4 = '{-3, -3, -3, 3, -3, -3};
`else
    l1 = '{2, -2, 2, 3, -2, 2};
    l3 = '{-50, 50, -50, 60, 50, 50};
    l4 = '{-4, -4, -4, 4, -4, -4};
`endif
    pin("model s1", s1, l1, 1'b1);
    pin("model s3", s3, l3, 1'b1);
    pin("model s4", s4, l4, 1'b0);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_q      = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_r", int'(bus.out_r), 0);
    chk("reset out_last", int'(bus.out_last), 0);
    chk("reset parity_ok", int'(bus.parity_ok), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_check(s1, 0, 0, 0);
    run_check(s3, 0, 0, 0);
    run_check(s4, 0, 0, 0);
    run_check(s1, 2, 3, l1[2]);

    send_q(s1, 3);
    rst_n = 1'b0;
    #1;
    chk("midreset in_ready", int'(bus.in_ready), 1);
    chk("midreset out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_check(s1, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
